displ_bcd_conv: RTL and testbench
=================================

Name: displ_bcd_conv

Overview:
Converts a 32-bit value written by the CPU into six 4-bit display digits. The decimal path uses an iterative double-dabble converter; the hex path is a passthrough. The block sits directly upstream of the six dig_displ_7_segs instances that drive HEX0..HEX5. The digit register changes only when a conversion completes, so the displays never show intermediate values. A one-deep pending buffer accepts a CPU write that arrives while a conversion is in progress.

Parameters:
NUM_DIGITS, 6, number of output digits (only the default is verified).
BIN_WIDTH, 20, number of binary bits converted, equal to the number of double-dabble iterations; must satisfy 2^BIN_WIDTH > 10^NUM_DIGITS - 1.

Ports:
clk  input  1  system clock, all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
wr_en  input  1  one-cycle load request.
wr_data  input  32  value to display.
hex_mode  input  1  sampled with wr_en: 1 selects hex, 0 selects decimal.
busy  output  1  decimal conversion in progress.
done  output  1  one-cycle pulse when digits has been updated.
ovf  output  1  last completed decimal request exceeded 10^NUM_DIGITS - 1.
digits  output  4*NUM_DIGITS  packed digits; digit0 (least significant) is at [3:0].

Behaviour:
- Reset (asynchronous, overrides everything):
  - State returns to IDLE.
  - digits = 0, busy = 0, done = 0, ovf = 0.
  - Pending buffer cleared.
  - Any conversion in progress is aborted and no done is produced.
- States: IDLE and CONV.
- done defaults to 0 on every edge unless set by a completion event below.
- Request source in IDLE:
  - wr_en = 1 uses (wr_data, hex_mode) and clears the pending buffer; a live write beats pending.
  - Otherwise, if the pending buffer is valid, its contents are used and the buffer is cleared.
- IDLE, hex request:
  - On that edge, digits <= wr_data[4*NUM_DIGITS-1:0], ovf <= 0, done <= 1.
  - State stays IDLE and busy stays 0. Latency is 1 cycle.
- IDLE, decimal request with wr_data > 10^NUM_DIGITS - 1 (full 32-bit compare):
  - digits <= all nibbles 9 (24'h999999), ovf <= 1, done <= 1.
  - State stays IDLE. Latency is 1 cycle.
- IDLE, decimal request in range:
  - Binary shift register <= wr_data[BIN_WIDTH-1:0].
  - BCD scratch <= 0, iteration counter <= 0.
  - State goes to CONV and busy <= 1.
- CONV, one iteration per cycle:
  - Every scratch nibble >= 5 has 3 added (4-bit add, no carry between nibbles).
  - {scratch, binary} is then shifted left by 1; the binary MSB enters scratch bit 0.
  - Counter increments.
- CONV completion, on the edge of iteration BIN_WIDTH:
  - digits <= adjusted-and-shifted scratch, ovf <= 0, done <= 1, busy <= 0.
  - State returns to IDLE.
  - Accept-to-done latency is BIN_WIDTH cycles (20 by default).
- wr_en during CONV, including on the completion edge:
  - (wr_data, hex_mode) is stored in the pending buffer and the valid flag is set.
  - A later write overwrites an earlier one (latest wins); the earlier one is dropped silently.
  - The current conversion is not disturbed.
- After completion, a valid pending request starts on the first IDLE edge, unless a live wr_en arrives on that same edge.
- digits and ovf hold their values between completions.
- Counter width is ceil(log2(BIN_WIDTH+1)); the counter never wraps during a conversion.

Test Plan:
- Decimal 123456: wr_en with hex_mode = 0 and wr_data = 123456 -> busy = 1 for 20 cycles; done pulses exactly 20 cycles after accept; digits = 24'h123456, ovf = 0.
- Hex passthrough: wr_data = 32'h00ABCDEF with hex_mode = 1 -> done pulses on the next cycle; digits = 24'hABCDEF, busy never asserted, ovf = 0.
- Boundaries:
  - decimal 0 -> 24'h000000;
  - decimal 999999 -> 24'h999999 with ovf = 0;
  - decimal 1000000 -> 24'h999999 with ovf = 1 after 1 cycle;
  - decimal 32'hFFFFFFFF -> ovf = 1;
  - a following in-range write clears ovf.
- Pending buffer: write decimal 42, then during busy write 7 and then 9 ->
  - first done gives digits = 24'h000042;
  - the next conversion starts one cycle later and its done gives 24'h000009;
  - no result 000007 ever appears;
  - exactly two done pulses.
- Write on the completion edge: write hex 32'h00000123 on the same edge as a decimal completion -> decimal result shown first, then digits = 24'h000123 one cycle after the next IDLE edge.
- Reset mid-operation: assert reset at iteration 10 of decimal 555555 with a pending write stored -> digits = 0, busy = 0, done never pulses, pending discarded; the next write converts normally.

Source files
------------

// File: rtl/displ_bcd_conv.sv
// displ_bcd_conv: turns a CPU-written 32-bit value into packed display digits.
// The decimal path runs a one-bit-per-cycle double-dabble converter. The hex
// path copies the low nibbles straight through. The visible digit register
// changes only on completion, so the displays never show partial results.
// A one-deep pending slot holds the latest write that arrives mid-conversion.
module displ_bcd_conv #(
   parameter int NUM_DIGITS = 6,
   parameter int BIN_WIDTH  = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [31:0]             wr_data,
   input  logic                    hex_mode,
   output logic                    busy,
   output logic                    done,
   output logic                    ovf,
   output logic [4*NUM_DIGITS-1:0] digits
);

   localparam int DW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(BIN_WIDTH + 1);
   localparam logic [31:0]   MAX_VAL   = 32'(10 ** NUM_DIGITS - 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(BIN_WIDTH - 1);

   typedef enum logic {IDLE, CONV} state_t;

   state_t                 state_q, state_d;
   logic [BIN_WIDTH-1:0]   bin_q, bin_d;
   logic [DW-1:0]          bcd_q, bcd_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DW-1:0]          digits_q, digits_d;
   logic                   ovf_q, ovf_d;
   logic                   done_q, done_d;
   logic                   pend_valid_q, pend_valid_d;
   logic [31:0]            pend_data_q, pend_data_d;
   logic                   pend_hex_q, pend_hex_d;

   // Request selected in IDLE: a live write has priority over the pending slot.
   logic                   req_valid;
   logic [31:0]            req_data;
   logic                   req_hex;

   // Double-dabble step: add 3 to every nibble >= 5, then shift one binary bit in.
   logic [DW-1:0]          bcd_adj;
   logic [DW-1:0]          bcd_shift;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                     bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
      end
   endgenerate

   assign bcd_shift = {bcd_adj[DW-2:0], bin_q[BIN_WIDTH-1]};

   assign busy   = (state_q == CONV);
   assign done   = done_q;
   assign ovf    = ovf_q;
   assign digits = digits_q;

   // Request source mux for IDLE.
   always_comb begin
      req_valid = 1'b0;
      req_data  = '0;
      req_hex   = 1'b0;
      if (wr_en) begin
         req_valid = 1'b1;
         req_data  = wr_data;
         req_hex   = hex_mode;
      end else if (pend_valid_q) begin
         req_valid = 1'b1;
         req_data  = pend_data_q;
         req_hex   = pend_hex_q;
      end
   end

   // Next-state logic: request dispatch in IDLE, one iteration per cycle in CONV.
   always_comb begin
      state_d      = state_q;
      bin_d        = bin_q;
      bcd_d        = bcd_q;
      cnt_d        = cnt_q;
      digits_d     = digits_q;
      ovf_d        = ovf_q;
      done_d       = 1'b0;
      pend_valid_d = pend_valid_q;
      pend_data_d  = pend_data_q;
      pend_hex_d   = pend_hex_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               pend_valid_d = 1'b0;
               if (req_hex) begin
                  digits_d = req_data[DW-1:0];
                  ovf_d    = 1'b0;
                  done_d   = 1'b1;
               end else if (req_data > MAX_VAL) begin
                  digits_d = {NUM_DIGITS{4'h9}};
                  ovf_d    = 1'b1;
                  done_d   = 1'b1;
               end else begin
                  bin_d   = req_data[BIN_WIDTH-1:0];
                  bcd_d   = '0;
                  cnt_d   = '0;
                  state_d = CONV;
               end
            end
         end
         CONV: begin
            bcd_d = bcd_shift;
            bin_d = {bin_q[BIN_WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               digits_d = bcd_shift;
               ovf_d    = 1'b0;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
            // Writes during a conversion park in the pending slot; latest wins.
            if (wr_en) begin
               pend_valid_d = 1'b1;
               pend_data_d  = wr_data;
               pend_hex_d   = hex_mode;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset aborts any conversion and discards the pending slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         bin_q        <= '0;
         bcd_q        <= '0;
         cnt_q        <= '0;
         digits_q     <= '0;
         ovf_q        <= 1'b0;
         done_q       <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
         pend_hex_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bin_q        <= bin_d;
         bcd_q        <= bcd_d;
         cnt_q        <= cnt_d;
         digits_q     <= digits_d;
         ovf_q        <= ovf_d;
         done_q       <= done_d;
         pend_valid_q <= pend_valid_d;
         pend_data_q  <= pend_data_d;
         pend_hex_q   <= pend_hex_d;
      end
   end

endmodule

// File: tb/tb_displ_bcd_conv.sv
// Bench for displ_bcd_conv: directed writes push expected results (digits,
// ovf, cycle of the done pulse) into a queue; a monitor pops on every done.
module tb_displ_bcd_conv;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic        hex_mode = 1'b0;
   logic        busy;
   logic        done;
   logic        ovf;
   logic [23:0] digits;

   typedef struct {
      logic [23:0] d;
      logic        o;
      int          at;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   displ_bcd_conv #(.NUM_DIGITS(6), .BIN_WIDTH(20)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .hex_mode (hex_mode),
      .busy     (busy),
      .done     (done),
      .ovf      (ovf),
      .digits   (digits)
   );

   always #5 clk = ~clk;

   // Edge counter; the monitor reads it at the following falling edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (done) begin
         $display("done cyc=%0d digits=%h ovf=%b", cyc, digits, ovf);
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got digits=%h expected no done", digits);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("digits", digits, e.d);
            chk("ovf", ovf, e.o);
            chk("done_cycle", cyc, e.at);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [23:0] d, input logic o, input int at);
      exp_t e;
      e.d = d;
      e.o = o;
      e.at = at;
      q.push_back(e);
   endtask

   // One-cycle write; returns just after the accepting edge.
   task automatic wr(input logic [31:0] d, input logic h);
      $display("write cyc=%0d data=%h hex=%b", cyc, d, h);
      wr_en = 1'b1;
      wr_data = d;
      hex_mode = h;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d results outstanding expected 0", q.size());
         q.delete();
      end
      tick();
   endtask

   initial begin
      int c0;
      tick();
      tick();
      chk("reset_digits", digits, 24'h0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_ovf", ovf, 0);
      reset = 1'b0;
      tick();

      // Decimal 123456: done 20 edges after accept.
      push(24'h123456, 1'b0, cyc + 21);
      wr(32'd123456, 1'b0);
      chk("busy_in_conv", busy, 1);
      drain();
      chk("busy_after_conv", busy, 0);

      // Hex passthrough: done on the accepting edge, never busy.
      push(24'hABCDEF, 1'b0, cyc + 1);
      wr(32'h00ABCDEF, 1'b1);
      chk("busy_hex", busy, 0);
      drain();

      // Boundaries.
      push(24'h000000, 1'b0, cyc + 21);
      wr(32'd0, 1'b0);
      drain();
      push(24'h999999, 1'b0, cyc + 21);
      wr(32'd999999, 1'b0);
      drain();
      push(24'h999999, 1'b1, cyc + 1);
      wr(32'd1000000, 1'b0);
      chk("busy_ovf", busy, 0);
      drain();
      push(24'h999999, 1'b1, cyc + 1);
      wr(32'hFFFFFFFF, 1'b0);
      drain();
      push(24'h000005, 1'b0, cyc + 21);
      wr(32'd5, 1'b0);
      drain();

      // Pending buffer: 7 is overwritten by 9 while 42 converts.
      c0 = cyc;
      push(24'h000042, 1'b0, c0 + 21);
      push(24'h000009, 1'b0, c0 + 42);
      wr(32'd42, 1'b0);
      tick();
      tick();
      tick();
      wr(32'd7, 1'b0);
      wr(32'd9, 1'b0);
      drain();

      // Hex write landing on the decimal completion edge.
      c0 = cyc;
      push(24'h000777, 1'b0, c0 + 21);
      push(24'h000123, 1'b0, c0 + 22);
      wr(32'd777, 1'b0);
      while (cyc < c0 + 20) tick();
      wr(32'h00000123, 1'b1);
      drain();

      // Reset at iteration 10 with a pending write stored.
      c0 = cyc;
      wr(32'd555555, 1'b0);
      wr(32'd8, 1'b0);
      while (cyc < c0 + 10) tick();
      reset = 1'b1;
      #1;
      chk("rst_mid_digits", digits, 24'h0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      tick();
      reset = 1'b0;
      repeat (30) tick();
      chk("rst_idle_busy", busy, 0);

      // Normal conversion after reset.
      push(24'h314159, 1'b0, cyc + 21);
      wr(32'd314159, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
